multi_pb_debouncer: RTL



---
 rtl/multi_pb_debouncer_if.sv | 32 +++
 rtl/multi_pb_debouncer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/multi_pb_debouncer_if.sv
// Push-button bundle between raw board inputs and the conditioned outputs.
//   pb_in        : raw active-high buttons, asynchronous to clk
//   pb_debounced : debounced level per channel
//   pb_press     : one-cycle pulse on debounced 0->1
//   pb_release   : one-cycle pulse on debounced 1->0
//   pb_long      : one-cycle pulse once a press has been held long enough
// master drives the buttons, slave is the debouncer.
interface multi_pb_debouncer_if #(
  parameter int unsigned NUM_CH = 4
) ();
  logic [NUM_CH-1:0] pb_in;
  logic [NUM_CH-1:0] pb_debounced;
  logic [NUM_CH-1:0] pb_press;
  logic [NUM_CH-1:0] pb_release;
  logic [NUM_CH-1:0] pb_long;

  modport master (
    output pb_in,
    input  pb_debounced,
    input  pb_press,
    input  pb_release,
    input  pb_long
  );

  modport slave (
    input  pb_in,
    output pb_debounced,
    output pb_press,
    output pb_release,
    output pb_long
  );
endinterface

// File: rtl/multi_pb_debouncer.sv
// N-channel push-button conditioner: per channel a synchroniser, a stability
// window counter and a RELEASED/PRESSED/LONG_HELD state machine.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of multi_pb_debouncer_if (raw buttons in, conditioned
//           level and press/release/long pulses out, all straight from flops)
module multi_pb_debouncer #(
  parameter int unsigned NUM_CH            = 4,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned STABLE_CYCLES     = 50000,
  parameter int unsigned LONG_PRESS_CYCLES = 1000000
) (
  input logic                   clk,
  input logic                   rst_n,
  multi_pb_debouncer_if.slave   bus
);

  localparam int unsigned StableW = $clog2(STABLE_CYCLES);
  localparam int unsigned HoldW   = $clog2(LONG_PRESS_CYCLES);
  localparam logic [StableW-1:0] StableMax = StableW'(STABLE_CYCLES - 1);
  localparam logic [HoldW-1:0]   HoldMax   = HoldW'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    StReleased = 2'd0,
    StPressed  = 2'd1,
    StLongHeld = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q     [NUM_CH];
  logic [NUM_CH-1:0]      sync_s;
  logic [StableW-1:0]     stab_cnt_q [NUM_CH];
  logic [StableW-1:0]     stab_cnt_d [NUM_CH];
  logic [HoldW-1:0]       hold_cnt_q [NUM_CH];
  logic [HoldW-1:0]       hold_cnt_d [NUM_CH];
  state_e                 state_q    [NUM_CH];
  state_e                 state_d    [NUM_CH];

  logic [NUM_CH-1:0] level_q, level_d;
  logic [NUM_CH-1:0] press_q, press_d;
  logic [NUM_CH-1:0] release_q, release_d;
  logic [NUM_CH-1:0] long_q, long_d;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sync_s[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // Stability window: any cycle agreeing with the current level restarts it.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_CH; i++) begin
      stab_cnt_d[i] = '0;
      if (sync_s[i] != level_q[i]) begin
        if (stab_cnt_q[i] == StableMax) begin
          level_d[i] = sync_s[i];
        end else begin
          stab_cnt_d[i] = stab_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Pulses are computed from level_d so they register on the same edge as
  // the level change. A fall takes priority over the long-press terminal.
  always_comb begin
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]    = state_q[i];
      hold_cnt_d[i] = hold_cnt_q[i];
      unique case (state_q[i])
        StReleased: begin
          if (level_d[i] && !level_q[i]) begin
            state_d[i]    = StPressed;
            press_d[i]    = 1'b1;
            hold_cnt_d[i] = '0;
          end
        end
        StPressed: begin
          if (!level_d[i]) begin
            state_d[i]    = StReleased;
            release_d[i]  = 1'b1;
            hold_cnt_d[i] = '0;
          end else if (hold_cnt_q[i] == HoldMax - 1'b1) begin
            state_d[i]    = StLongHeld;
            long_d[i]     = 1'b1;
            hold_cnt_d[i] = HoldMax;
          end else begin
            hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
          end
        end
        StLongHeld: begin
          if (!level_d[i]) begin
            state_d[i]    = StReleased;
            release_d[i]  = 1'b1;
            hold_cnt_d[i] = '0;
          end
        end
        default: begin
          state_d[i]    = StReleased;
          hold_cnt_d[i] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sync_q[i]     <= '0;
        stab_cnt_q[i] <= '0;
        hold_cnt_q[i] <= '0;
        state_q[i]    <= StReleased;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        sync_q[i]     <= {sync_q[i][SYNC_STAGES-2:0], bus.pb_in[i]};
        stab_cnt_q[i] <= stab_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
        state_q[i]    <= state_d[i];
      end
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign bus.pb_debounced = level_q;
  assign bus.pb_press     = press_q;
  assign bus.pb_release   = release_q;
  assign bus.pb_long      = long_q;

endmodule
